// File: rtl/mem_dump_engine.sv
// Streams {addr, data} for a programmable address range read from a synchronous memory.
// Latency: RD_LATENCY+2 cycles per word; DUMP_* held while DUMP_READY=0, only ABORT drops a word.
module mem_dump_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] CFG_START_ADDR,
    input  logic [ADDR_WIDTH-1:0] CFG_END_ADDR,
    input  logic [ADDR_WIDTH-1:0] CFG_STRIDE,
    output logic                  MEM_RD_EN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
    output logic                  DUMP_VALID,
    input  logic                  DUMP_READY,
    output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
    output logic [DATA_WIDTH-1:0] DUMP_DATA,
    output logic                  DUMP_LAST,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [CNT_WIDTH-1:0]  WORD_COUNT
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_OUT, S_FIN} state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur, end_addr, stride;
    logic [2:0]            lat_cnt;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_last;
    logic                  err_pulse;
    logic [CNT_WIDTH-1:0]  word_count;
    logic                  cfg_bad;
    logic [ADDR_WIDTH:0]   next_sum;
    logic                  is_last;

    assign cfg_bad  = CFG_START_ADDR > CFG_END_ADDR;
    // One extra bit so a carry past the top of the address space ends the range instead of wrapping.
    assign next_sum = {1'b0, cur} + {1'b0, stride};
    assign is_last  = next_sum > {1'b0, end_addr};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        MEM_RD_EN  = 1'b0;
        DUMP_VALID = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: begin
                if (START && !ABORT && !cfg_bad) state_nxt = S_READ;
            end
            S_READ: begin
                MEM_RD_EN = 1'b1;
                BUSY      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (lat_cnt == 3'd0) state_nxt = S_OUT;
            end
            S_OUT: begin
                DUMP_VALID = 1'b1;
                BUSY       = 1'b1;
                if (DUMP_READY) state_nxt = dump_last ? S_FIN : S_READ;
            end
            S_FIN: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (ABORT && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur        <= '0;
            end_addr   <= '0;
            stride     <= '0;
            lat_cnt    <= '0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            err_pulse  <= 1'b0;
            word_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        if (cfg_bad) begin
                            err_pulse <= 1'b1;
                        end else begin
                            cur        <= CFG_START_ADDR;
                            end_addr   <= CFG_END_ADDR;
                            stride     <= (CFG_STRIDE == '0) ? ONE_ADDR : CFG_STRIDE;
                            word_count <= '0;
                        end
                    end
                end
                S_READ: lat_cnt <= LAT_INIT;
                S_WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end else if (!ABORT) begin
                        dump_addr <= cur;
                        dump_data <= MEM_RD_DATA;
                        dump_last <= is_last;
                    end
                end
                S_OUT: begin
                    if (DUMP_READY && !ABORT) begin
                        if (word_count != '1) word_count <= word_count + ONE_CNT;
                        if (!dump_last) cur <= next_sum[ADDR_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign MEM_ADDR   = cur;
    assign DUMP_ADDR  = dump_addr;
    assign DUMP_DATA  = dump_data;
    assign DUMP_LAST  = dump_last;
    assign ERR        = err_pulse;
    assign WORD_COUNT = word_count;

endmodule

// File: doc/mem_dump_engine.md
Name: mem_dump_engine

Overview:
Synthesizable successor to the bench-side memory dump. It walks a programmable address range of any synchronous memory (instruction or data memory of the pipelined MIPS core), reads one word per address, and streams {address, data} out over a valid/ready interface. Compared with the fixed-range dump, it adds runtime range and stride, configurable memory read latency, backpressure, abort, error reporting and a transfer count. It sits beside the memory as a debug/readback port and is muxed onto the memory read port while BUSY=1.

Parameters:
ADDR_WIDTH, 32, width of memory address and range registers
DATA_WIDTH, 32, width of memory data word
RD_LATENCY, 1, memory read latency in cycles (legal 1..4)
CNT_WIDTH, 16, width of WORD_COUNT

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  one-cycle pulse, begins a dump; sampled only in IDLE
ABORT  in  1  terminates any dump; priority over START
CFG_START_ADDR  in  ADDR_WIDTH  first address
CFG_END_ADDR  in  ADDR_WIDTH  last address, inclusive
CFG_STRIDE  in  ADDR_WIDTH  address increment; 0 treated as 1
MEM_RD_EN  out  1  memory read strobe
MEM_ADDR  out  ADDR_WIDTH  memory read address
MEM_RD_DATA  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after MEM_RD_EN
DUMP_VALID  out  1  output word valid
DUMP_READY  in  1  consumer accepts word
DUMP_ADDR  out  ADDR_WIDTH  address of current word
DUMP_DATA  out  DATA_WIDTH  data of current word
DUMP_LAST  out  1  current word is the final word of the range
BUSY  out  1  dump in progress
DONE  out  1  one-cycle pulse on normal completion
ERR  out  1  one-cycle pulse on rejected START
WORD_COUNT  out  CNT_WIDTH  words accepted in current/last dump, saturating

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0, including WORD_COUNT, MEM_ADDR, DUMP_*.
- FSM states: IDLE, READ, WAIT, OUT, FIN.
- IDLE: BUSY=0. On START with CFG_START_ADDR > CFG_END_ADDR, pulse ERR for 1 cycle and stay in IDLE. On a valid START, latch the configuration (later CFG changes are ignored), set cur=CFG_START_ADDR, clear WORD_COUNT, go to READ.
- READ (1 cycle): MEM_RD_EN=1, MEM_ADDR=cur, go to WAIT. At most one read is outstanding.
- WAIT: a down-counter runs for RD_LATENCY cycles. If MEM_RD_EN is high at cycle t, MEM_RD_DATA is registered into DUMP_DATA at the edge ending cycle t+RD_LATENCY, and the FSM enters OUT. DUMP_VALID is high from cycle t+RD_LATENCY+1.
- OUT: DUMP_VALID=1. DUMP_ADDR/DATA/LAST are held stable until DUMP_READY=1.
- DUMP_LAST=1 when cur+stride exceeds end. The sum is computed in ADDR_WIDTH+1 bits, so a carry out also counts as last; no wrap-around to address 0.
- Handshake (VALID&READY): WORD_COUNT increments, saturating at all-ones. If LAST, go to FIN. Otherwise cur+=stride and go to READ.
- Minimum period per word is RD_LATENCY+2 cycles.
- FIN: DONE=1 for one cycle, BUSY drops, go to IDLE. DUMP_VALID is 0 in FIN.
- BUSY=1 in READ, WAIT and OUT.
- ABORT in any non-IDLE state: next state is IDLE and DUMP_VALID drops without a handshake. This is the only exception to the hold rule. No DONE pulse. WORD_COUNT is retained. Any read still in flight is discarded.
- ABORT and START together in IDLE: ABORT wins, no dump starts, no ERR.
- START while BUSY is ignored.
- A single-word range (start==end) produces one word with DUMP_LAST=1.
- RST asserted mid-dump returns to IDLE immediately; no DONE pulse.

Test Plan:
- Basic, RD_LATENCY=1: memory[i]=i*3; range 0x0..0x4, stride 1, DUMP_READY=1 -> 5 words, addresses 0..4, data 0,3,6,9,12. LAST only on address 4. DONE pulses once. WORD_COUNT=5. Each word 3 cycles apart.
- Stride and backpressure: range 0x10..0x20, stride 8; DUMP_READY low for 4 cycles on the second word -> addresses 0x10,0x18,0x20. DUMP_DATA/ADDR stay stable while stalled. WORD_COUNT=3.
- Error and zero stride: start=0x8, end=0x4 -> ERR pulses 1 cycle, BUSY stays 0. Then start=end=0x7, stride=0 -> one word at 0x7 with LAST=1, then DONE.
- Wrap guard: ADDR_WIDTH=8, range 0xF0..0xFF, stride 0x20 -> single word at 0xF0 with LAST=1 (carry). No access to 0x10.
- Abort: dump 0x0..0x3FF; ABORT asserted while in OUT with WORD_COUNT=10 -> next cycle DUMP_VALID=0, BUSY=0, no DONE, WORD_COUNT=10. A following START runs normally.
- Latency sweep, RD_LATENCY=3: memory[i]=~i; range 0..2 -> DUMP_VALID rises 4 cycles after each MEM_RD_EN. Data 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD. An async RST pulse mid-WAIT clears all outputs immediately.
